i2c_temp_sensor_slave: RTL and testbench
========================================

# i2c_temp_sensor_slave

I2C responder emulating the on-board temperature sensor at 7-bit address 0x4B, read-only. It answers the sensor-polling master's read sequence: address ACK, temperature MSB, master ACK, LSB, master NACK. It drives SDA from a 16-bit `temp_in` word. It sits in the simulation/loopback build in place of the physical sensor, and on the PMOD header when the FPGA stands in for the sensor. It is clocked by the same 200 kHz system clock that generates the 10 kHz SCL.

## Interface
- `SLAVE_ADDR`, default 7'h4B: 7-bit address the block responds to.
- `clk_200kHz`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `SCL`  in  1: I2C clock from master, asynchronous to `clk_200kHz` sampling.
- `SDA`  inout  1: open-drain. The block only ever drives 0 or releases (z).
- `temp_in`  in  16: temperature word; the snapshot is served MSB byte first.
- `busy`  out  1: high from a detected START until return to IDLE.
- `rd_done`  out  1: one-cycle pulse when a complete 2-byte read ends with master NACK.

## Operation
- **Input sampling:** SCL and SDA each pass through a 2-flop synchronizer plus a previous-value register. This gives rise/fall strobes.
- **Bus conditions:**
  - START: SDA fall while SCL high.
  - STOP: SDA rise while SCL high.
  - START/repeated START in any state: release SDA, clear the bit counter, go to ADDR.
  - STOP in any state: release SDA, go to IDLE.
- **IDLE:** wait for START.
- **ADDR:** shift SDA in on 8 SCL rises, MSB first.
  - After the 8th rise, if {addr, rw} == {SLAVE_ADDR, 1}: capture `temp_in` into the 16-bit shadow, then go to ADDR_ACK.
  - Otherwise go to IDLE. SDA is never driven; `busy` drops.
- **ADDR_ACK:** drive SDA low from the next SCL fall until the following SCL fall, then go to TX_MSB.
- **TX_MSB / TX_LSB:** on each SCL fall, present the next shadow bit, MSB first. Drive low for 0; release for 1. Hold the bit through the SCL high phase.
  - After 8 bits, release SDA on the SCL fall and go to M_ACK (after MSB) or M_NACK (after LSB).
- **M_ACK:** sample SDA on the SCL rise.
  - 0: go to TX_LSB.
  - 1: go to IDLE with no `rd_done`.
- **M_NACK:** sample SDA on the SCL rise.
  - 1: pulse `rd_done`, then go to IDLE.
  - 0: master wants more; wrap to TX_MSB with the same shadow.
- **Shadow register:** loaded only at address match. Changes to `temp_in` mid-transfer do not affect bytes in flight.

## Timing
- **Reset values:** state IDLE, SDA released (z), `busy`=0, `rd_done`=0, shadow=0, bit counter=0.
- **Reset mid-drive:** reset releases SDA combinationally and immediately.
- **Detection latency:** a pin edge is seen as a strobe 3 `clk_200kHz` cycles later (2 sync + 1 edge).
- **SDA update latency:** SDA changes 1 cycle after an SCL-fall strobe, i.e. 4 cycles after the SCL pin falls. This is well inside the 10-cycle low half-period.
- **SDA sampling point:** on the SCL-rise strobe (3 cycles after the pin rises). The master holds SDA for the full high phase.
- **Simultaneous events:** if START/STOP and an SCL edge strobe occur in the same cycle, START/STOP wins.
- **`busy`:**
  - Asserts the cycle after the START strobe.
  - Deasserts on entry to IDLE.
  - Stays high across repeated STARTs.
- **`rd_done`:** asserts exactly one cycle, coincident with the IDLE transition from M_NACK.
- **Counters:**
  - Bit counter is 3 bits, counting 7→0. It wraps only via state change, never free-running.

## Structure
- **Shared package `i2c_pkg`:**
  - Slave state enum: IDLE, ADDR, ADDR_ACK, TX_MSB, M_ACK, TX_LSB, M_NACK.
  - `SENSOR_ADDR` = 7'h4B.
  - Read/write bit constants.
- **Sub-module `i2c_line_sync`:** 2-flop synchronizer plus edge detect, with outputs `level`, `rise`, `fall`. Instantiated once for SCL and once for SDA.
- **Top level:** the FSM, shift register, shadow, and open-drain assign live here.

## Test plan
1. **Basic read.** Master reads 0x97, `temp_in`=16'h0C80. Expect:
   - SDA low on the 9th clock.
   - Bytes 0x0C then 0x80 on the bus.
   - `rd_done` pulses once after the master NACK; `busy` then falls.
2. **Wrong address.** Address byte 0x91 (0x48, read). Expect no ACK: SDA stays released for the whole frame, and `busy` falls after the 8th SCL rise.
3. **Write request.** Address byte 0x96 (write bit). Expect no ACK and a return to IDLE.
4. **Snapshot isolation.** `temp_in` changes 0x0C80→0x1900 during TX_MSB. Expect:
   - LSB sent is still 0x80.
   - The next read returns 0x19, 0x00.
5. **Repeated START.** Repeated START issued during TX_MSB bit 4. Expect:
   - SDA released within 4 cycles.
   - A new 0x97 is ACKed and the read completes normally.
   - No `rd_done` for the aborted read.
6. **Reset and ACK-wrap.** Expect:
   - Reset asserted while SDA is driven low: SDA goes z the same cycle and all outputs return to reset values.
   - Separately, master ACK after the LSB: the slave re-sends 0x0C.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, sensor address and R/W bit values.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX_MSB,
        M_ACK,
        TX_LSB,
        M_NACK
    } slave_state_t;

    localparam logic [6:0] SENSOR_ADDR = 7'h4B;
    localparam logic       RW_READ     = 1'b1;
    localparam logic       RW_WRITE    = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge detect for one I2C line.
// level/rise/fall are mutually aligned and trail the pin by 3 clk_200kHz cycles.
module i2c_line_sync #(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk_200kHz,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clk_200kHz or posedge reset) begin
        if (reset) begin
            sync <= {2{IDLE_LEVEL}};
            prev <= IDLE_LEVEL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            prev <= sync[1];
            rise <= sync[1] & ~prev;
            fall <= ~sync[1] & prev;
        end
    end

    // prev carries the same sample the strobes were derived from
    assign level = prev;

endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// Read-only I2C responder standing in for the temperature sensor; serves a temp_in snapshot MSB first.
// SDA moves 4 cycles after an SCL pin fall; open-drain, only ever pulls low or releases.
module i2c_temp_sensor_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = SENSOR_ADDR
) (
    input  logic        clk_200kHz,
    input  logic        reset,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] temp_in,
    output logic        busy,
    output logic        rd_done
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk_200kHz (clk_200kHz),
        .reset      (reset),
        .pin        (SCL),
        .level      (scl_level),
        .rise       (scl_rise),
        .fall       (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk_200kHz (clk_200kHz),
        .reset      (reset),
        .pin        (SDA),
        .level      (sda_level),
        .rise       (sda_rise),
        .fall       (sda_fall)
    );

    slave_state_t state, state_nxt;
    logic [2:0]   bit_cnt, bit_cnt_nxt;
    logic [6:0]   addr_sr, addr_sr_nxt;
    logic [15:0]  shadow, shadow_nxt;
    logic         sda_low, sda_low_nxt;
    logic         armed, armed_nxt;
    logic         busy_nxt, rd_done_nxt;
    logic         start_cond, stop_cond, tx_hi;

    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;

    always_ff @(posedge clk_200kHz or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            addr_sr <= 7'd0;
            shadow  <= 16'd0;
            sda_low <= 1'b0;
            armed   <= 1'b0;
            busy    <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            addr_sr <= addr_sr_nxt;
            shadow  <= shadow_nxt;
            sda_low <= sda_low_nxt;
            armed   <= armed_nxt;
            busy    <= busy_nxt;
            rd_done <= rd_done_nxt;
        end
    end

    // armed: in ADDR_ACK the ACK is on the bus; in TX states a data bit is on the bus
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        addr_sr_nxt = addr_sr;
        shadow_nxt  = shadow;
        sda_low_nxt = sda_low;
        armed_nxt   = armed;
        busy_nxt    = busy;
        rd_done_nxt = 1'b0;
        tx_hi       = (state == TX_MSB);

        if (start_cond) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = 3'd7;
            sda_low_nxt = 1'b0;
            armed_nxt   = 1'b0;
            busy_nxt    = 1'b1;
        end else if (stop_cond) begin
            state_nxt   = IDLE;
            sda_low_nxt = 1'b0;
            armed_nxt   = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    addr_sr_nxt = {addr_sr[5:0], sda_level};
                    if (bit_cnt == 3'd0) begin
                        if ({addr_sr, sda_level} == {SLAVE_ADDR, RW_READ}) begin
                            shadow_nxt = temp_in;
                            state_nxt  = ADDR_ACK;
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!armed) begin
                        sda_low_nxt = 1'b1;
                        armed_nxt   = 1'b1;
                    end else begin
                        state_nxt   = TX_MSB;
                        bit_cnt_nxt = 3'd7;
                        sda_low_nxt = ~shadow[15];
                    end
                end
                TX_MSB, TX_LSB: if (scl_fall) begin
                    if (!armed) begin
                        armed_nxt   = 1'b1;
                        bit_cnt_nxt = 3'd7;
                        sda_low_nxt = ~shadow[{tx_hi, 3'd7}];
                    end else if (bit_cnt == 3'd0) begin
                        armed_nxt   = 1'b0;
                        sda_low_nxt = 1'b0;
                        state_nxt   = tx_hi ? M_ACK : M_NACK;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                        sda_low_nxt = ~shadow[{tx_hi, bit_cnt - 3'd1}];
                    end
                end
                M_ACK: if (scl_rise) begin
                    if (!sda_level) begin
                        state_nxt = TX_LSB;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
                M_NACK: if (scl_rise) begin
                    if (sda_level) begin
                        state_nxt   = IDLE;
                        busy_nxt    = 1'b0;
                        rd_done_nxt = 1'b1;
                    end else begin
                        state_nxt = TX_MSB;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // reset gates the driver directly so the bus is freed without waiting for a clock
    assign SDA = (sda_low && !reset) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_temp_sensor_slave.sv
// Bench for i2c_temp_sensor_slave: bit-level I2C master, table of directed reads, hand sequences
// for repeated START and reset-while-driving, plus random reads against a byte-level model.
module tb_i2c_temp_sensor_slave;
    import i2c_pkg::*;

    logic        clk_200kHz = 1'b0;
    logic        reset;
    logic        m_scl;
    logic        m_sda_low;
    logic [15:0] temp_in;
    logic        busy;
    logic        rd_done;
    wire         sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk_200kHz = ~clk_200kHz;

    i2c_temp_sensor_slave dut (
        .clk_200kHz (clk_200kHz),
        .reset      (reset),
        .SCL        (m_scl),
        .SDA        (sda_bus),
        .temp_in    (temp_in),
        .busy       (busy),
        .rd_done    (rd_done)
    );

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;

    always @(negedge clk_200kHz) if (rd_done === 1'b1) rd_cnt++;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] temp;
        logic [15:0] mid;
        int          n;
        logic        ack;
        logic [31:0] bytes;
        int          rd;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_200kHz);
    endtask

    // every bit starts just after SCL falls: data at +5, SCL high +10..+20
    task automatic write_bit(input logic b, output logic busy_hi);
        cyc(5); m_sda_low = ~b;
        cyc(5); m_scl = 1'b1;
        cyc(9); busy_hi = busy;
        cyc(1); m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        cyc(5); m_sda_low = 1'b0;
        cyc(5); m_scl = 1'b1;
        cyc(5); b = sda_bus;
        cyc(5); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            cyc(5); m_sda_low = 1'b0;
            cyc(5); m_scl = 1'b1;
            cyc(5);
        end
        m_sda_low = 1'b1;
        cyc(10); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(5); m_sda_low = 1'b1;
        cyc(5); m_scl = 1'b1;
        cyc(5); m_sda_low = 1'b0;
        cyc(10);
    endtask

    task automatic send_addr(input logic [7:0] a, output logic ack, output logic busy8);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(a[i], busy8);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_bytes(input int n, input logic [15:0] mid, output logic [31:0] got);
        logic b, dummy;
        logic [7:0] byt;
        got = 32'd0;
        for (int k = 0; k < n; k++) begin
            byt = 8'd0;
            for (int j = 7; j >= 0; j--) begin
                read_bit(b);
                byt = {byt[6:0], b};
                if (k == 0 && j == 5) temp_in = mid;
            end
            got = {got[23:0], byt};
            write_bit(k == n - 1, dummy);
        end
    endtask

    task automatic run_txn(input string name, input vec_t v);
        logic ack, busy8;
        logic [31:0] got;
        int rd0;
        temp_in = v.temp;
        rd0 = rd_cnt;
        i2c_start();
        check({name, " busy_after_start"}, busy, 1);
        send_addr(v.addr, ack, busy8);
        check({name, " addr_ack"}, ack, v.ack);
        check({name, " busy_after_8th_rise"}, busy8, v.ack);
        if (v.ack) begin
            read_bytes(v.n, v.mid, got);
            check({name, " bytes"}, got, v.bytes);
        end
        i2c_stop();
        check({name, " rd_done_pulses"}, rd_cnt - rd0, v.rd);
        check({name, " busy_idle"}, busy, 0);
    endtask

    // byte-level view: matching read gets alternating MSB/LSB of the snapshot;
    // rd_done only if the NACK lands after an LSB
    function automatic vec_t model(input logic [7:0] addr, input logic [15:0] temp,
                                   input logic [15:0] mid, input int n);
        vec_t v;
        v.addr  = addr;
        v.temp  = temp;
        v.mid   = mid;
        v.n     = n;
        v.ack   = (addr == 8'h97);
        v.bytes = 32'd0;
        for (int k = 0; k < n; k++)
            v.bytes = {v.bytes[23:0], (k % 2 == 0) ? temp[15:8] : temp[7:0]};
        v.rd    = (v.ack && n % 2 == 0) ? 1 : 0;
        return v;
    endfunction

    initial begin
        logic ack, busy8, b7, b6, b5;
        logic [31:0] got;
        int rd0;
        vec_t v;

        tbl[0] = '{8'h97, 16'h0C80, 16'h0C80, 2, 1'b1, 32'h0000_0C80, 1};
        tbl[1] = '{8'h91, 16'h0C80, 16'h0C80, 0, 1'b0, 32'h0, 0};
        tbl[2] = '{{SENSOR_ADDR, RW_WRITE}, 16'h0C80, 16'h0C80, 0, 1'b0, 32'h0, 0};
        tbl[3] = '{8'h97, 16'h0C80, 16'h1900, 2, 1'b1, 32'h0000_0C80, 1};
        tbl[4] = '{8'h97, 16'h1900, 16'h1900, 2, 1'b1, 32'h0000_1900, 1};
        tbl[5] = '{8'h97, 16'h0C80, 16'h0C80, 4, 1'b1, 32'h0C80_0C80, 1};

        m_scl     = 1'b1;
        m_sda_low = 1'b0;
        temp_in   = 16'h0;
        reset     = 1'b1;
        cyc(3);
        check("reset busy", busy, 0);
        check("reset rd_done", rd_done, 0);
        check("reset sda", sda_bus, 1);
        reset = 1'b0;
        cyc(5);

        for (int i = 0; i < 6; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

        // repeated START while bit 4 (a 1) of the MSB is on the bus
        temp_in = 16'h1900;
        rd0 = rd_cnt;
        i2c_start();
        send_addr(8'h97, ack, busy8);
        check("rs first ack", ack, 1);
        read_bit(b7); read_bit(b6); read_bit(b5);
        check("rs msb top bits", {b7, b6, b5}, 3'b000);
        i2c_start();
        check("rs busy held", busy, 1);
        m_sda_low = 1'b0;
        cyc(4);
        check("rs sda released", sda_bus, 1);
        send_addr(8'h97, ack, busy8);
        check("rs second ack", ack, 1);
        read_bytes(2, 16'h1900, got);
        check("rs bytes", got, 32'h1900);
        i2c_stop();
        check("rs rd_done pulses", rd_cnt - rd0, 1);
        check("rs busy idle", busy, 0);

        // reset while the address ACK is being driven low
        temp_in = 16'h0C80;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(tbl[0].addr[i], busy8);
        cyc(6);
        check("ack driven low", sda_bus, 0);
        reset = 1'b1;
        #1;
        check("reset mid-drive sda", sda_bus, 1);
        check("reset mid-drive busy", busy, 0);
        check("reset mid-drive rd_done", rd_done, 0);
        cyc(3);
        reset = 1'b0;
        i2c_stop();

        for (int i = 0; i < 10; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 1) ? 8'h97 : 8'($urandom);
            v = model(a, 16'($urandom), 16'($urandom), $urandom_range(1, 4));
            run_txn($sformatf("rnd%0d", i), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
